// File: rtl/tts_sched_pkg.sv
// rtl/tts_sched_pkg.sv - shared types and constants for the frame update scheduler
package tts_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int FRAME_COUNT_W = 8;

  localparam int PLAYER      = 0;
  localparam int DRAGON_HEAD = 1;
  localparam int DRAGON_BODY = 2;

endpackage

// File: rtl/frame_update_scheduler_if.sv
// rtl/frame_update_scheduler_if.sv - frame/start/done bundle between sync, scheduler and clients
interface frame_update_scheduler_if
  import tts_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int DIV_WIDTH   = 6
);
  logic                             frame_end;
  logic                             pause;
  logic [NUM_CLIENTS*DIV_WIDTH-1:0] period;
  logic [NUM_CLIENTS-1:0]           done;
  logic [NUM_CLIENTS-1:0]           start;
  logic                             busy;
  logic [FRAME_COUNT_W-1:0]         frame_count;
  logic                             overrun;
  logic                             timeout;

  // Scheduler side: issues start strobes, consumes frame and done events.
  modport master (
    input  frame_end, pause, period, done,
    output start, busy, frame_count, overrun, timeout
  );

  // Sync generator / client side.
  modport slave (
    output frame_end, pause, period, done,
    input  start, busy, frame_count, overrun, timeout
  );
endinterface

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - per-client frame divider, due every period+1 advances
module frame_divider #(
  parameter int DIV_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adv,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 due,
  output logic [DIV_WIDTH-1:0] cnt
);

  // Reload on zero so a new period only takes effect at the next reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (adv) begin
      if (cnt == '0) cnt <= period;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign due = (cnt == '0);

endmodule

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - sequences due game-logic clients once per accepted frame
module frame_update_scheduler
  import tts_sched_pkg::*;
#(
  parameter int NUM_CLIENTS    = 3,
  parameter int DIV_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                        clk,
  input logic                        reset,
  frame_update_scheduler_if.master   bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e             state_q, state_d;
  logic [NUM_CLIENTS-1:0]   mask_q, mask_d;
  logic [NUM_CLIENTS-1:0]   due;
  logic [NUM_CLIENTS-1:0]   active;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [FRAME_COUNT_W-1:0] fc_q, fc_d;
  logic [NUM_CLIENTS-1:0]   start_q, start_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout_q, timeout_d;
  logic                     frame_live;
  logic                     accept;
  logic [DIV_WIDTH-1:0]     div_cnt_unused [NUM_CLIENTS];

  // Lowest set bit as a one-hot vector; index 0 has highest priority.
  function automatic logic [NUM_CLIENTS-1:0] lowest_bit(input logic [NUM_CLIENTS-1:0] m);
    return m & (~m + NUM_CLIENTS'(1));
  endfunction

  assign frame_live = bus.frame_end & ~bus.pause;
  assign accept     = frame_live & (state_q == IDLE);

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_div
    frame_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
      .clk    (clk),
      .reset  (reset),
      .adv    (accept),
      .period (bus.period[i*DIV_WIDTH +: DIV_WIDTH]),
      .due    (due[i]),
      .cnt    (div_cnt_unused[i])
    );
  end

  // Next-state, mask bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    fc_d      = fc_q;
    timeout_d = 1'b0;
    overrun_d = frame_live & (state_q != IDLE);
    active    = lowest_bit(mask_q);

    if (accept) fc_d = fc_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d = due;
          if (|due) state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (|(bus.done & active)) begin
          mask_d  = mask_q & ~active;
          state_d = (|mask_d) ? ISSUE : IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          mask_d    = mask_q & ~active;
          state_d   = (|mask_d) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == ISSUE) ? lowest_bit(mask_d) : '0;
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      tmo_q     <= '0;
      fc_q      <= '0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      tmo_q     <= tmo_d;
      fc_q      <= fc_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = fc_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - directed self-checking bench for frame_update_scheduler
module tb_frame_update_scheduler;

  logic clk;
  logic reset;

  frame_update_scheduler_if #(.NUM_CLIENTS(3), .DIV_WIDTH(6)) bus ();

  frame_update_scheduler #(
    .NUM_CLIENTS(3), .DIV_WIDTH(6), .TIMEOUT_CYCLES(1023)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         t_accept;
  int         st_time [3];
  logic [2:0] started;
  int         st_count;
  int         busy_fall;
  int         tmo_time;
  int         ovr_seen;

  logic [2:0] exp_div [6] = '{3'b111, 3'b001, 3'b101, 3'b011, 3'b101, 3'b001};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller raises frame_end; this captures it, then plays the clients until busy falls.
  task automatic run_seq(input int dly, input logic [2:0] answer, input int ovr_at,
                         input bit fe_last, input int budget);
    int cd [3];
    bit fin;
    started   = '0;
    st_count  = 0;
    busy_fall = -1;
    tmo_time  = -1;
    ovr_seen  = 0;
    st_time   = '{-1, -1, -1};
    for (int i = 0; i < 3; i++) cd[i] = 0;
    t_accept = cyc;
    tick();
    bus.frame_end = 1'b0;
    fin = 1'b0;
    for (int k = 1; k <= budget && !fin; k++) begin
      bus.done      = '0;
      bus.frame_end = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin
            bus.done[i] = 1'b1;
            if (fe_last && i == 2) bus.frame_end = 1'b1;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (bus.start[i]) begin
          st_time[i] = cyc;
          started[i] = 1'b1;
          st_count++;
          if (answer[i]) cd[i] = dly;
        end
      end
      if (bus.timeout) tmo_time = cyc;
      if (bus.overrun) ovr_seen++;
      if (k == ovr_at) bus.frame_end = 1'b1;
      if (!bus.busy) begin
        busy_fall = cyc;
        fin = 1'b1;
      end else begin
        tick();
      end
    end
    bus.done      = '0;
    bus.frame_end = 1'b0;
    check("seq_finished", 32'(fin), 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.frame_end = 1'b0;
    bus.pause     = 1'b0;
    bus.period    = '0;
    bus.done      = '0;
    tick();
    tick();
    check("rst_start",   32'(bus.start), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_fc",      32'(bus.frame_count), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    reset = 1'b0;
    tick();

    // Start-up: all periods 0, clients answer 3 cycles after their strobe.
    bus.frame_end = 1'b1;
    run_seq(3, 3'b111, -1, 1'b0, 100);
    check("su_started",   32'(started), 32'b111);
    check("su_count",     st_count, 3);
    check("su_lat0",      st_time[0] - t_accept, 1);
    check("su_gap01",     st_time[1] - st_time[0], 4);
    check("su_gap12",     st_time[2] - st_time[1], 4);
    check("su_busy_fall", busy_fall - st_time[2], 4);
    check("su_fc",        32'(bus.frame_count), 1);

    // Dividers: periods {0, 2, 1} over six frames.
    bus.period = {6'd1, 6'd2, 6'd0};
    for (int f = 0; f < 6; f++) begin
      bus.frame_end = 1'b1;
      run_seq(1, 3'b111, -1, 1'b0, 50);
      check($sformatf("div_frame%0d", f + 1), 32'(started), 32'(exp_div[f]));
    end
    check("div_fc", 32'(bus.frame_count), 7);

    // Pause: three frames ignored, dividers frozen.
    bus.pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
      check("pause_start",   32'(bus.start), 0);
      check("pause_overrun", 32'(bus.overrun), 0);
      tick();
      check("pause_busy",    32'(bus.busy), 0);
    end
    check("pause_fc", 32'(bus.frame_count), 7);
    bus.pause  = 1'b0;
    bus.period = '0;
    bus.frame_end = 1'b1;
    run_seq(1, 3'b111, -1, 1'b0, 50);
    check("pause_release_started", 32'(started), 32'b111);
    check("pause_release_fc",      32'(bus.frame_count), 8);

    // Client 1 never answers; an extra frame arrives during its WAIT.
    bus.frame_end = 1'b1;
    run_seq(1, 3'b101, 100, 1'b0, 1200);
    check("tmo_delay",      tmo_time - st_time[1], 1025);
    check("tmo_next_start", st_time[2] - tmo_time, 0);
    check("tmo_started",    32'(started), 32'b111);
    check("ovr_pulses",     ovr_seen, 1);
    check("ovr_fc",         32'(bus.frame_count), 9);

    // Done arrives on the very cycle the timeout would expire.
    bus.frame_end = 1'b1;
    run_seq(1024, 3'b111, -1, 1'b0, 3300);
    check("tie_no_timeout", tmo_time, -1);
    check("tie_gap01",      st_time[1] - st_time[0], 1025);
    check("tie_count",      st_count, 3);

    // frame_end coincides with the final done: dropped as an overrun.
    bus.frame_end = 1'b1;
    run_seq(2, 3'b111, -1, 1'b1, 50);
    check("last_done_ovr", ovr_seen, 1);
    check("last_done_fc",  32'(bus.frame_count), 11);
    tick();
    tick();
    check("last_done_idle", 32'(bus.busy), 0);

    // Reset during client 1's WAIT.
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    check("mid_start0", 32'(bus.start), 32'b001);
    tick();
    bus.done = 3'b001;
    tick();
    bus.done = '0;
    check("mid_start1", 32'(bus.start), 32'b010);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_start", 32'(bus.start), 0);
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_fc",    32'(bus.frame_count), 0);
    reset = 1'b0;
    tick();
    check("mid_rst_no_reissue", 32'(bus.start), 0);
    bus.frame_end = 1'b1;
    run_seq(1, 3'b111, -1, 1'b0, 50);
    check("post_rst_first", st_time[0] - t_accept, 1);
    check("post_rst_order", 32'(st_time[1] > st_time[0] && st_time[2] > st_time[1]), 1);
    check("post_rst_fc",    32'(bus.frame_count), 1);

    // frame_count wraps 255 -> 0.
    for (int f = 0; f < 254; f++) begin
      bus.frame_end = 1'b1;
      run_seq(1, 3'b111, -1, 1'b0, 50);
    end
    check("fc_255", 32'(bus.frame_count), 255);
    bus.frame_end = 1'b1;
    run_seq(1, 3'b111, -1, 1'b0, 50);
    check("fc_wrap", 32'(bus.frame_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_update_scheduler.md
# frame_update_scheduler

Per-frame sequencer for the game-logic clients (player logic, dragon head, dragon body). On each accepted `frame_end` pulse from the sync generator, it works out which clients are due from their per-client frame dividers. It then issues a one-cycle `start` strobe to each due client in fixed priority order, and waits for that client's `done` before moving to the next. It sits between `sync_generator` and the game-logic blocks, replacing their ad-hoc vsync and movement-delay counters.

## Interface
- `NUM_CLIENTS`, default 3: number of sequenced clients; index 0 has highest priority.
- `DIV_WIDTH`, default 6: width of each client's frame-period field.
- `TIMEOUT_CYCLES`, default 1023: maximum WAIT cycles per client before forced advance.

Ports. One clock; reset is synchronous and active-high.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; drive from `~rst_n`.
- `frame_end` input 1: single-cycle pulse at end of frame.
- `pause` input 1: level; while high, `frame_end` is ignored.
- `period` input NUM_CLIENTS*DIV_WIDTH: client i occupies bits [i*DIV_WIDTH +: DIV_WIDTH]; the client runs every period+1 frames.
- `done` input NUM_CLIENTS: client completion pulse or level.
- `start` output NUM_CLIENTS: one-hot, one-cycle start strobe.
- `busy` output 1: high while a sequence is in progress.
- `frame_count` output 8: accepted-frame counter; wraps 255 to 0.
- `overrun` output 1: one-cycle pulse when `frame_end` arrives while busy.
- `timeout` output 1: one-cycle pulse when a client is force-advanced.

## Operation
- **Reset values:** every output is 0, the FSM is in IDLE, all divider counters are 0, the due mask is 0 and the timeout counter is 0.
- **Accepted frame:** `frame_end`=1, `pause`=0 and FSM in IDLE.
  - `frame_count` increments.
  - Every divider updates: if cnt==0 the client is due and cnt loads `period[i]`; otherwise cnt decrements.
  - New `period` values therefore take effect only at reload.
  - The due mask is latched.
- **Ignored frame while paused:** dividers and `frame_count` are frozen, and there is no overrun pulse.
- **Frame while busy:** if `frame_end`=1 and the FSM is not in IDLE (and not paused), the frame is dropped and `overrun` pulses. Dividers and `frame_count` do not change.
- **FSM states:**
  - IDLE → ISSUE on an accepted frame with a nonzero due mask. With an all-zero mask it stays in IDLE; `frame_count` still increments.
  - ISSUE: `start[idx]`=1, where idx is the lowest set bit of the due mask. The timeout counter clears. Always goes to WAIT next cycle.
  - WAIT: the timeout counter increments.
    - On `done[idx]`=1, or on counter==TIMEOUT_CYCLES with no done (this case also pulses `timeout`), clear mask bit idx.
    - If the remaining mask is nonzero go to ISSUE, else go to IDLE.
  - `done` wins over timeout in the same cycle.
- **Done handling:** `done` is sampled only in WAIT and only for the active idx. Done from other clients, and done during ISSUE, is ignored.
- **Pause mid-sequence:** `pause` does not interrupt a running sequence; it completes normally.
- **Reset mid-operation:** the sequence is abandoned, the cycle after reset all outputs are at reset values, and no pending start is re-issued.

## Timing
- All outputs are registered.
- `frame_end` accepted in cycle t:
  - `start[idx]` is high in t+1 only.
  - `busy` is high from t+1.
- Done seen in WAIT at cycle w:
  - The next `start` is at w+1 if clients remain.
  - Otherwise `busy` drops at w+1.
- Minimum per-client turnaround is 2 cycles (ISSUE + one WAIT cycle), so a client responds at the earliest one cycle after its strobe.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and cannot wrap, because it clears in ISSUE.
- `frame_count` is modulo-256 with no saturation.
- Dividers are DIV_WIDTH-bit unsigned and never underflow, because of the cnt==0 reload.

## Structure
- Shared package `tts_sched_pkg`:
  - the FSM state enum (IDLE, ISSUE, WAIT);
  - `FRAME_COUNT_W` = 8;
  - the default client indices (PLAYER=0, DRAGON_HEAD=1, DRAGON_BODY=2).
- Sub-module `frame_divider`: one instance per client. It takes `clk`, `reset`, an advance enable and `period`, and outputs `due` and its counter. It holds the reload/decrement logic.
- The lowest-set-bit priority select is an inline function in the top module, not a separate module.

## Test plan
- **Reset start-up:** reset, then `frame_end` with all periods = 0 and clients answering `done` 3 cycles after `start` → strobes on `start` 0, 1, 2 in order, each 4 cycles apart; `busy` falls 4 cycles after the last strobe; `frame_count` = 1.
- **Dividers:** periods {0, 2, 1} over 6 accepted frames → client 0 runs 6×, client 1 runs at frames 1 and 4, client 2 runs at frames 1, 3 and 5.
- **Overrun:** client 1 never answers and TIMEOUT_CYCLES = 1023.
  - → `timeout` pulses exactly 1024 cycles after client 1's WAIT entry, then client 2 is started.
  - A second `frame_end` during WAIT → one `overrun` pulse and `frame_count` unchanged.
- **Pause:** `pause` held high across 3 `frame_end` pulses → no `start`, no `overrun`, `frame_count` and dividers unchanged. Release, then next `frame_end` → normal sequence.
- **Simultaneous events:** `done` and timeout expiry in the same cycle → no `timeout` pulse. `frame_end` on the cycle the last `done` arrives → `overrun` pulses and the frame is dropped.
- **Reset mid-WAIT:** assert reset mid-WAIT of client 1 → the next cycle has `start` = 0, `busy` = 0 and `frame_count` = 0. After release, the first `frame_end` starts client 0.
